// File: rtl/arp_rx.sv
// Receive-side ARP parser: validates ARP request/reply frames addressed to this station and
// hands the sender's addresses to the ARP transmitter (request) or announces them (reply).
module arp_rx #(
  parameter bit CHECK_DEST_MAC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_end,
  input  logic        rx_crc_err,
  output logic        arp_reply_req,
  input  logic        arp_reply_ack,
  output logic [31:0] arp_rec_source_ip_addr,
  output logic [47:0] arp_rec_source_mac_addr,
  output logic        arp_found
);

  typedef enum logic [1:0] {StIdle, StRec, StCheck} state_e;

  state_e      state;
  logic [10:0] byte_cnt;
  logic        err;
  logic        not_bcast;
  logic        not_local;
  logic        crc_err_q;
  logic        op_reply;
  logic [47:0] mac_shadow;
  logic [31:0] ip_shadow;

  logic        byte_err;
  logic        byte_not_bcast;
  logic        byte_not_local;
  logic [47:0] mac_shift;
  logic [31:0] ip_shift;
  logic [1:0]  ip_ofs;
  logic        dest_bad;
  logic        commit_ok;

  // Per-byte check against the expected header content at index byte_cnt.
  always_comb begin
    mac_shift      = local_mac_addr << {byte_cnt[2:0], 3'b000};
    ip_ofs         = byte_cnt[1:0] + 2'd2;  // maps indices 38..41 onto 0..3
    ip_shift       = local_ip_addr << {ip_ofs, 3'b000};
    byte_err       = 1'b0;
    byte_not_bcast = 1'b0;
    byte_not_local = 1'b0;
    if (byte_cnt < 11'd6) begin
      byte_not_bcast = (rx_data != 8'hff);
      byte_not_local = (rx_data != mac_shift[47:40]);
    end
    case (byte_cnt)
      11'd12: byte_err = (rx_data != 8'h08);
      11'd13: byte_err = (rx_data != 8'h06);
      11'd14: byte_err = (rx_data != 8'h00);
      11'd15: byte_err = (rx_data != 8'h01);
      11'd16: byte_err = (rx_data != 8'h08);
      11'd17: byte_err = (rx_data != 8'h00);
      11'd18: byte_err = (rx_data != 8'h06);
      11'd19: byte_err = (rx_data != 8'h04);
      11'd20: byte_err = (rx_data != 8'h00);
      11'd21: byte_err = (rx_data != 8'h01) && (rx_data != 8'h02);
      11'd38, 11'd39, 11'd40, 11'd41: byte_err = (rx_data != ip_shift[31:24]);
      default: ;
    endcase
  end

  always_comb begin
    dest_bad  = CHECK_DEST_MAC && not_bcast && not_local;
    commit_ok = !err && !dest_bad && (byte_cnt >= 11'd42) && !crc_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= StIdle;
      byte_cnt                <= '0;
      err                     <= 1'b0;
      not_bcast               <= 1'b0;
      not_local               <= 1'b0;
      crc_err_q               <= 1'b0;
      op_reply                <= 1'b0;
      mac_shadow              <= '0;
      ip_shadow               <= '0;
      arp_reply_req           <= 1'b0;
      arp_found               <= 1'b0;
      arp_rec_source_ip_addr  <= '0;
      arp_rec_source_mac_addr <= '0;
    end else begin
      arp_found <= 1'b0;
      if (arp_reply_req && arp_reply_ack) begin
        arp_reply_req <= 1'b0;
      end

      // Bytes arriving during StCheck are dropped.
      if (rx_valid && (state != StCheck)) begin
        err       <= err | byte_err;
        not_bcast <= not_bcast | byte_not_bcast;
        not_local <= not_local | byte_not_local;
        if (byte_cnt != 11'h7ff) begin
          byte_cnt <= byte_cnt + 11'd1;
        end
        if ((byte_cnt >= 11'd22) && (byte_cnt <= 11'd27)) begin
          mac_shadow <= {mac_shadow[39:0], rx_data};
        end
        if ((byte_cnt >= 11'd28) && (byte_cnt <= 11'd31)) begin
          ip_shadow <= {ip_shadow[23:0], rx_data};
        end
        if (byte_cnt == 11'd21) begin
          op_reply <= (rx_data == 8'h02);
        end
      end

      case (state)
        StIdle: begin
          // A lone rx_end with no data is an empty frame and is ignored.
          if (rx_valid) begin
            if (rx_end) begin
              crc_err_q <= rx_crc_err;
              state     <= StCheck;
            end else begin
              state <= StRec;
            end
          end
        end
        StRec: begin
          if (rx_end) begin
            crc_err_q <= rx_crc_err;
            state     <= StCheck;
          end
        end
        StCheck: begin
          if (commit_ok) begin
            if (op_reply) begin
              arp_found <= 1'b1;
              if (!arp_reply_req) begin
                arp_rec_source_ip_addr  <= ip_shadow;
                arp_rec_source_mac_addr <= mac_shadow;
              end
            end else if (!arp_reply_req) begin
              arp_rec_source_ip_addr  <= ip_shadow;
              arp_rec_source_mac_addr <= mac_shadow;
              arp_reply_req           <= 1'b1;
            end
          end
          byte_cnt  <= '0;
          err       <= 1'b0;
          not_bcast <= 1'b0;
          not_local <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
